// File: rtl/seq_det_pkg.sv
// seq_det_pkg - shared state encodings and defaults for the 1010 detector family
package seq_det_pkg;
    // FSM state encodings, shared with the detector cs/ns debug outputs.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;

    // Serializer defaults.
    localparam int   SER_WIDTH    = 8;
    localparam logic SER_IDLE_BIT = 1'b0;
endpackage

// File: rtl/ser_hold_reg.sv
// rtl/ser_hold_reg.sv - one-entry word buffer in front of the serializer shifter
//   clk, rst_n : clock, asynchronous active-low clear
//   push, din  : write din into the entry (entry becomes full)
//   pop        : consume the entry (entry becomes empty unless pushed at the same edge)
//   dout, full : stored word and occupancy flag
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        if (push) begin
            data_d = din;
        end
        // A push at the same edge as a pop refills the entry.
        full_d = push | (full_q & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;
endmodule

// File: rtl/seq_det_bit_serializer.sv
// rtl/seq_det_bit_serializer.sv - parallel-to-serial front end feeding the 1010 detectors
//   Clk, Rst               : clock, asynchronous active-low reset
//   Din, Din_Valid         : upstream word and its valid
//   Din_Ready              : hold register empty; accept = Din_Valid & Din_Ready
//   Sout, Sout_Valid       : registered serial bit and data-bit qualifier
//   Word_Start             : pulse on the first bit of each word
//   Busy                   : shifter active or hold register full
//   cs                     : current FSM state (debug)
module seq_det_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int   WIDTH     = SER_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_Valid,
    output logic             Din_Ready,
    output logic             Sout,
    output logic             Sout_Valid,
    output logic             Word_Start,
    output logic             Busy,
    output logic [1:0]       cs
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             ws_q, ws_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             xfer;

    assign accept = Din_Valid & ~hold_full;
    // The shifter takes a new word when it is empty or showing its final bit.
    assign xfer   = hold_full & ((state_q == ST_IDLE) | (state_q == ST_LAST));

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk   (Clk),
        .rst_n (Rst),
        .push  (accept),
        .pop   (xfer),
        .din   (Din),
        .dout  (hold_data),
        .full  (hold_full)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. cnt_q counts bits still to be shown after the current one,
    // so cnt_q==1 in SHIFT means this edge puts the final bit on Sout.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = xfer ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = (cnt_q == CW'(1)) ? ST_LAST : ST_SHIFT;
            ST_LAST:  state_d = xfer ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        Sout_Valid = (state_q == ST_SHIFT) | (state_q == ST_LAST);
        Busy       = (state_q != ST_IDLE) | hold_full;
        Din_Ready  = ~hold_full;
        Sout       = sout_q;
        Word_Start = ws_q;
        cs         = state_q;
    end

    // Shifter and bit counter. sout_q holds the bit on the wire; sh_q holds
    // the bits not yet shown, aligned so the next one is at the exit end.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        sout_d = IDLE_BIT;
        ws_d   = 1'b0;
        if (xfer) begin
            cnt_d = CW'(WIDTH - 1);
            ws_d  = 1'b1;
            if (MSB_FIRST) begin
                sout_d = hold_data[WIDTH-1];
                sh_d   = {hold_data[WIDTH-2:0], 1'b0};
            end else begin
                sout_d = hold_data[0];
                sh_d   = {1'b0, hold_data[WIDTH-1:1]};
            end
        end else if (state_q == ST_SHIFT) begin
            cnt_d = cnt_q - CW'(1);
            if (MSB_FIRST) begin
                sout_d = sh_q[WIDTH-1];
                sh_d   = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sout_d = sh_q[0];
                sh_d   = {1'b0, sh_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            sout_q <= IDLE_BIT;
            ws_q   <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            sout_q <= sout_d;
            ws_q   <= ws_d;
        end
    end
endmodule
